// File: rtl/pixel_window_engine.sv
// Streaming KxK binary-pixel window engine.
// Accepts K-pixel columns, slides a KxK window across each line, applies one of four
// per-line ops and packs result pixels LSB-first into OUT_W-bit words with valid/ready.
module pixel_window_engine #(
    parameter int unsigned K     = 3,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned THR_W = $clog2(K*K+1),
    parameter int unsigned CNT_W = $clog2(OUT_W+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       cfg_mode,
    input  logic [THR_W-1:0] cfg_thresh,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K-1:0]     in_col,
    input  logic             in_eol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_word,
    output logic [CNT_W-1:0] out_count,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned CC_W = $clog2(K);
    localparam int unsigned CTR  = (K-1)/2;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [K-1:0][K-1:0]     r_win;
    logic [CC_W-1:0]         r_col_cnt;
    logic [1:0]              r_mode;
    logic [THR_W-1:0]        r_thresh;
    logic [CNT_W-1:0]        r_pk_cnt;
    logic [OUT_W-1:0]        r_acc;
    logic                    r_out_valid;
    logic [OUT_W-1:0]        r_out_word;
    logic [CNT_W-1:0]        r_out_count;
    logic                    r_out_last;

    logic                    w_accept;
    logic                    w_pix_en;
    logic [K-1:0][K-1:0]     w_win_next;
    logic                    w_and;
    logic                    w_or;
    logic [THR_W-1:0]        w_pop;
    logic                    w_pixel;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic [OUT_W-1:0]        w_acc_new;
    logic                    w_full;

    // Output register is free whenever it is empty or being popped this cycle.
    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_pix_en  = w_accept && (r_state == S_RUN);

    // Window after shifting in the arriving column; pixel is formed from this without delay.
    always_comb begin
        for (int i = 0; i < int'(K) - 1; i++) begin
            w_win_next[i] = r_win[i+1];
        end
        w_win_next[K-1] = in_col;
    end

    // Reduce the new window according to the mode latched at line start.
    always_comb begin
        w_and   = 1'b1;
        w_or    = 1'b0;
        w_pop   = '0;
        w_pixel = 1'b0;
        for (int i = 0; i < int'(K); i++) begin
            for (int j = 0; j < int'(K); j++) begin
                w_and = w_and & w_win_next[i][j];
                w_or  = w_or  | w_win_next[i][j];
                w_pop = w_pop + THR_W'(w_win_next[i][j]);
            end
        end
        case (r_mode)
            2'd0:    w_pixel = w_win_next[CTR][CTR];
            2'd1:    w_pixel = w_and;
            2'd2:    w_pixel = w_or;
            default: w_pixel = (w_pop >= r_thresh);
        endcase
    end

    // Packer view with the current pixel appended.
    assign w_cnt_inc = r_pk_cnt + CNT_W'(1);
    assign w_acc_new = r_acc | (OUT_W'(w_pixel) << r_pk_cnt);
    assign w_full    = w_pix_en && (w_cnt_inc == CNT_W'(OUT_W));

    // Line FSM, window, cfg latch, packer and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_win       <= '0;
            r_col_cnt   <= '0;
            r_mode      <= '0;
            r_thresh    <= '0;
            r_pk_cnt    <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_count <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (in_eol) begin
                    // Close the line: full word, partial flush or empty marker, all with last set.
                    r_out_valid <= 1'b1;
                    r_out_word  <= w_pix_en ? w_acc_new : '0;
                    r_out_count <= w_pix_en ? w_cnt_inc : '0;
                    r_out_last  <= 1'b1;
                    r_win       <= '0;
                    r_col_cnt   <= '0;
                    r_pk_cnt    <= '0;
                    r_acc       <= '0;
                    r_state     <= S_FILL;
                end else begin
                    r_win <= w_win_next;
                    if (r_state == S_FILL) begin
                        if (r_col_cnt == '0) begin
                            r_mode   <= cfg_mode;
                            r_thresh <= cfg_thresh;
                        end
                        r_col_cnt <= r_col_cnt + CC_W'(1);
                        if (r_col_cnt == CC_W'(K-2)) begin
                            r_state <= S_RUN;
                        end
                    end
                    if (w_pix_en) begin
                        if (w_full) begin
                            r_out_valid <= 1'b1;
                            r_out_word  <= w_acc_new;
                            r_out_count <= CNT_W'(OUT_W);
                            r_out_last  <= 1'b0;
                            r_pk_cnt    <= '0;
                            r_acc       <= '0;
                        end else begin
                            r_pk_cnt <= w_cnt_inc;
                            r_acc    <= w_acc_new;
                        end
                    end
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign out_count = r_out_count;
    assign out_last  = r_out_last;
    assign busy      = (r_state == S_RUN) || (r_col_cnt != '0) || r_out_valid;

endmodule

// File: tb/tb_pixel_window_engine.sv
// Directed bench for pixel_window_engine (K=3, OUT_W=32).
module tb_pixel_window_engine;

    localparam int unsigned K     = 3;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned THR_W = 4;
    localparam int unsigned CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       cfg_mode;
    logic [THR_W-1:0] cfg_thresh;
    logic             in_valid;
    logic             in_ready;
    logic [K-1:0]     in_col;
    logic             in_eol;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_word;
    logic [CNT_W-1:0] out_count;
    logic             out_last;
    logic             busy;

    typedef struct packed {
        logic [OUT_W-1:0] w;
        logic [CNT_W-1:0] c;
        logic             l;
    } word_t;

    word_t q[$];
    int    n_vec = 0;
    int    n_err = 0;

    pixel_window_engine #(.K(K), .OUT_W(OUT_W), .THR_W(THR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_mode   (cfg_mode),
        .cfg_thresh (cfg_thresh),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_col     (in_col),
        .in_eol     (in_eol),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_count  (out_count),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Record every word the consumer takes (handshake is stable across the low phase).
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q.push_back({out_word, out_count, out_last});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [K-1:0] col, input logic eol);
        int t = 0;
        in_valid = 1'b1;
        in_col   = col;
        in_eol   = eol;
        while (!in_ready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t == 100) chk("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_eol   = 1'b0;
    endtask

    task automatic send_n(input logic [K-1:0] col, input int n, input logic eol_last);
        for (int i = 0; i < n; i++) begin
            send(col, eol_last && (i == n - 1));
        end
    endtask

    task automatic expect_word(input string tag, input logic [OUT_W-1:0] w,
                               input logic [CNT_W-1:0] c, input logic l);
        word_t x;
        chk({tag, "_avail"}, 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
            x = q.pop_front();
            chk({tag, "_word"},  64'(x.w), 64'(w));
            chk({tag, "_count"}, 64'(x.c), 64'(c));
            chk({tag, "_last"},  64'(x.l), 64'(l));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_mode   = 2'd0;
        cfg_thresh = '0;
        in_valid   = 1'b0;
        in_col     = '0;
        in_eol     = 1'b0;
        out_ready  = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_word",  64'(out_word),  64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Erode: five all-ones columns -> three 1 pixels
        cfg_mode = 2'd1;
        send(3'b111, 1'b0);
        chk("t1_busy_mid", 64'(busy), 64'd1);
        send_n(3'b111, 3, 1'b0);
        send(3'b111, 1'b1);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        idle(2);
        chk("t1_busy_end", 64'(busy), 64'd0);
        expect_word("t1", 32'h0000_0007, 6'd3, 1'b1);
        chk("t1_qempty", 64'(q.size()), 64'd0);

        // Dilate: 36 columns -> 34 pixels, one full word then a 2-pixel flush
        cfg_mode = 2'd2;
        send_n(3'b010, 36, 1'b1);
        idle(2);
        expect_word("t2a", 32'hFFFF_FFFF, 6'd32, 1'b0);
        expect_word("t2b", 32'h0000_0003, 6'd2,  1'b1);
        chk("t2_qempty", 64'(q.size()), 64'd0);

        // Threshold 5 on alternating columns -> 1,0,1,0
        cfg_mode   = 2'd3;
        cfg_thresh = 4'd5;
        send(3'b111, 1'b0);
        send(3'b000, 1'b0);
        send(3'b111, 1'b0);
        send(3'b000, 1'b0);
        send(3'b111, 1'b0);
        send(3'b000, 1'b1);
        idle(2);
        expect_word("t3", 32'h0000_0005, 6'd4, 1'b1);

        // Threshold 0 forces 1, threshold above K*K forces 0
        cfg_thresh = 4'd0;
        send_n(3'b000, 3, 1'b1);
        idle(2);
        expect_word("t3_thr0", 32'h0000_0001, 6'd1, 1'b1);
        cfg_thresh = 4'd10;
        send_n(3'b111, 3, 1'b1);
        idle(2);
        expect_word("t3_thr10", 32'h0000_0000, 6'd1, 1'b1);

        // Backpressure on the first full word, then pop+load in one cycle
        cfg_mode  = 2'd2;
        out_ready = 1'b0;
        send_n(3'b010, 34, 1'b0);
        chk("t4_held_valid", 64'(out_valid), 64'd1);
        chk("t4_in_ready",   64'(in_ready),  64'd0);
        chk("t4_held_word",  64'(out_word),  64'h0000_0000_FFFF_FFFF);
        chk("t4_held_count", 64'(out_count), 64'd32);
        chk("t4_held_last",  64'(out_last),  64'd0);
        in_valid = 1'b1;
        in_col   = 3'b010;
        in_eol   = 1'b0;
        idle(3);
        chk("t4_stall_ready", 64'(in_ready),  64'd0);
        chk("t4_stall_word",  64'(out_word),  64'h0000_0000_FFFF_FFFF);
        chk("t4_stall_q",     64'(q.size()),  64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t4_popped", 64'(out_valid), 64'd0);
        send(3'b010, 1'b1);
        chk("t4_flush_count", 64'(out_count), 64'd2);
        send(3'b010, 1'b1);
        chk("t4_pl_valid", 64'(out_valid), 64'd1);
        chk("t4_pl_count", 64'(out_count), 64'd0);
        chk("t4_pl_last",  64'(out_last),  64'd1);
        idle(2);
        expect_word("t4a", 32'hFFFF_FFFF, 6'd32, 1'b0);
        expect_word("t4b", 32'h0000_0003, 6'd2,  1'b1);
        expect_word("t4c", 32'h0000_0000, 6'd0,  1'b1);
        chk("t4_qempty", 64'(q.size()), 64'd0);

        // Short line gives an empty last word; next 3-column line gives one pixel
        send(3'b010, 1'b0);
        send(3'b010, 1'b1);
        idle(2);
        expect_word("t5_short", 32'h0000_0000, 6'd0, 1'b1);
        cfg_mode = 2'd0;
        send(3'b000, 1'b0);
        send(3'b010, 1'b0);
        send(3'b000, 1'b1);
        idle(2);
        expect_word("t5_centre", 32'h0000_0001, 6'd1, 1'b1);

        // Asynchronous reset with a word pending, then mid-line mode change is ignored
        cfg_mode  = 2'd2;
        out_ready = 1'b0;
        send_n(3'b010, 34, 1'b0);
        chk("t6_pre_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_busy",  64'(busy),      64'd0);
        chk("t6_rst_count", 64'(out_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        out_ready = 1'b1;
        cfg_mode  = 2'd1;
        send(3'b111, 1'b0);
        cfg_mode  = 2'd2;
        send(3'b111, 1'b0);
        send(3'b111, 1'b0);
        send(3'b110, 1'b0);
        send(3'b111, 1'b1);
        idle(2);
        expect_word("t6", 32'h0000_0001, 6'd3, 1'b1);
        chk("t6_qempty", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
